// File: rtl/lcd_req_arbiter_pkg.sv
// Shared definitions for the LCD request arbiter.
// Holds the lcd_ctrl command codes, the arbiter FSM state encodings and the
// transaction sizing constants (image length, window beats, WAIT_RSP timeout).
package lcd_req_arbiter_pkg;

  // lcd_ctrl command codes
  localparam logic [2:0] CMD_REFLASH = 3'd0;
  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_SHIFT_R = 3'd2;
  localparam logic [2:0] CMD_SHIFT_L = 3'd3;
  localparam logic [2:0] CMD_SHIFT_U = 3'd4;
  localparam logic [2:0] CMD_SHIFT_D = 3'd5;

  // Arbiter FSM state encodings
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Transaction sizing
  localparam int IMG_BYTES = 36;  // 6x6 image streamed after LOAD
  localparam int WIN_BYTES = 9;   // 3x3 window beats per command
  localparam int TIMEOUT   = 64;  // cycles allowed in WAIT_RSP

  // Sized forms used directly in comparisons
  localparam logic [5:0] LAST_BYTE = 6'(IMG_BYTES - 1);
  localparam logic [3:0] WIN_LAST  = 4'(WIN_BYTES);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

endpackage

// File: rtl/lcd_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant selector.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : grant evaluation enable (asserted only in ARB)
//   req[1:0]   : request levels
//   upd        : load the last-grant pointer (asserted in DONE)
//   upd_id     : index of the requester that just finished
//   gnt_id     : selected requester index
//   gnt_any    : a grant is being made this cycle
// The pointer resets to 1 so that requester 0 wins the first contest.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       gnt_id,
  output logic       gnt_any
);

  logic last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  // Under contention the requester not granted last wins; a lone request
  // wins outright regardless of the pointer.
  always_comb begin
    gnt_any = en & (|req);
    gnt_id  = (req == 2'b11) ? ~last_q : req[1];
  end

endmodule

// File: rtl/lcd_req_arbiter.sv
// lcd_req_arbiter: shares one lcd_ctrl between two requesters.
// Grants whole transactions round-robin: one command, plus the 36-byte image
// for LOAD, then forwards the 9 window beats back to the owner.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req[1:0]              : transaction request levels
//   req_cmd0/1, req_data0/1 : per-requester command and image byte
//   data_rd[1:0]          : one-hot byte pull strobe to the granted requester
//   grant, done, err      : ownership, end-of-transaction pulse, error qualifier
//   rsp_data/valid/id     : window beats routed to the owner
//   lcd_cmd/cmd_valid/datain, lcd_busy/output_valid/dataout : lcd_ctrl side
//   fsm_state             : current FSM state (debug observation)
// Handshake: a requester holds req until its done pulse; data_rd in cycle N
// means the requester presents its next byte on req_data in cycle N+1. The
// LCD side sees a single-cycle lcd_cmd_valid and then, for LOAD, one byte per
// cycle with no backpressure.
module lcd_req_arbiter
  import lcd_req_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [2:0] req_cmd0,
  input  logic [2:0] req_cmd1,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] data_rd,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       err,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic       lcd_output_valid,
  input  logic [7:0] lcd_dataout,
  output logic [2:0] fsm_state
);

  logic [2:0] state;
  logic       id_q;
  logic [2:0] cmd_q;
  logic       err_q;
  logic [5:0] byte_cnt;
  logic [3:0] beat_cnt;
  logic [7:0] tmo_cnt;

  logic       arb_id;
  logic       arb_any;
  logic [2:0] arb_cmd;
  logic [1:0] id_hot;
  logic       active;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (state == S_ARB),
    .req     (req),
    .upd     (state == S_DONE),
    .upd_id  (id_q),
    .gnt_id  (arb_id),
    .gnt_any (arb_any)
  );

  assign arb_cmd = arb_id ? req_cmd1 : req_cmd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      id_q     <= 1'b0;
      cmd_q    <= 3'd0;
      err_q    <= 1'b0;
      byte_cnt <= 6'd0;
      beat_cnt <= 4'd0;
      tmo_cnt  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((req != 2'b00) && !lcd_busy) state <= S_ARB;
        end
        S_ARB: begin
          if (!arb_any) begin
            // request withdrawn before it could be granted
            state <= S_IDLE;
          end else begin
            id_q  <= arb_id;
            cmd_q <= arb_cmd;
            if (arb_cmd > CMD_SHIFT_D) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q <= 1'b0;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          byte_cnt <= 6'd0;
          beat_cnt <= 4'd0;
          tmo_cnt  <= 8'd0;
          state    <= (cmd_q == CMD_LOAD) ? S_LOAD : S_WAIT;
        end
        S_LOAD: begin
          if (byte_cnt == LAST_BYTE) state <= S_WAIT;
          else                       byte_cnt <= byte_cnt + 6'd1;
        end
        S_WAIT: begin
          if (lcd_output_valid && (beat_cnt != 4'hF)) beat_cnt <= beat_cnt + 4'd1;
          // a completed window wins over a simultaneous timeout
          if ((beat_cnt >= WIN_LAST) && !lcd_busy) begin
            state <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so reset clears them next cycle.
  always_comb begin
    id_hot        = id_q ? 2'b10 : 2'b01;
    active        = (state == S_ISSUE) || (state == S_LOAD) ||
                    (state == S_WAIT)  || (state == S_DONE);
    grant         = active ? id_hot : 2'b00;
    done          = (state == S_DONE) ? id_hot : 2'b00;
    err           = (state == S_DONE) & err_q;
    // ISSUE pulls byte 0; stream cycle k pulls byte k+1, so the final
    // stream cycle needs no pull.
    data_rd       = (((state == S_ISSUE) && (cmd_q == CMD_LOAD)) ||
                     ((state == S_LOAD) && (byte_cnt != LAST_BYTE))) ? id_hot : 2'b00;
    lcd_cmd_valid = (state == S_ISSUE);
    lcd_cmd       = (state == S_ISSUE) ? cmd_q : 3'd0;
    // The requester's byte register already lands one cycle after data_rd,
    // which lines byte k up with stream cycle k; forward it as-is.
    lcd_datain    = (state == S_LOAD) ? (id_q ? req_data1 : req_data0) : 8'd0;
    rsp_valid     = (state == S_WAIT) & lcd_output_valid;
    rsp_data      = (state == S_WAIT) ? lcd_dataout : 8'd0;
    rsp_id        = active & id_q;
    fsm_state     = state;
  end

endmodule
